// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes, funct codes, ALU codes.
// State BNE exists only when MC_BNE_EN is defined.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
`ifdef MC_BNE_EN
        S_JUMP   = 4'd11,
        S_BNE    = 4'd12
`else
        S_JUMP   = 4'd11
`endif
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps the controller's aluop plus the R-type funct field to an ALU control code.
// Purely combinational.
module aludec
    import mc_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o
);

    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_ADD: alucontrol_o = ALU_ADD;
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alucontrol_o = ALU_ADD;
                    FUNCT_SUB: alucontrol_o = ALU_SUB;
                    FUNCT_AND: alucontrol_o = ALU_AND;
                    FUNCT_OR:  alucontrol_o = ALU_OR;
                    FUNCT_SLT: alucontrol_o = ALU_SLT;
                    default:   alucontrol_o = ALU_ADD;
                endcase
            end
            default: alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM controller for a multicycle MIPS datapath with a unified, handshaked memory.
// Define MC_BNE_EN to add the BNE state; otherwise op 000101 decodes as an illegal no-op.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic       pcen,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    aluop_t     aluop_c;
    logic       iord_c, memwrite_c, irwrite_c, regdst_c, memtoreg_c, regwrite_c, alusrca_c;
    logic       pcwrite_c, branch_c, bne_c;
    logic [1:0] alusrcb_c, pcsrc_c;
    logic [2:0] alucontrol_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        aluop_c    = ALUOP_ADD;
        iord_c     = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        regdst_c   = 1'b0;
        memtoreg_c = 1'b0;
        regwrite_c = 1'b0;
        alusrca_c  = 1'b0;
        pcwrite_c  = 1'b0;
        branch_c   = 1'b0;
        bne_c      = 1'b0;
        alusrcb_c  = 2'b00;
        pcsrc_c    = 2'b00;
        case (state_q)
            S_FETCH: begin
                alusrcb_c = 2'b01;
                irwrite_c = memready;
                pcwrite_c = memready;
                if (memready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb_c = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = S_BNE;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord_c = 1'b1;
                if (memready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            // Store keeps the write strobe up until memory accepts it.
            S_MEMWR: begin
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
                if (memready) state_d = S_FETCH;
            end
            S_EXEC: begin
                alusrca_c = 1'b1;
                aluop_c   = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                regdst_c   = 1'b1;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca_c = 1'b1;
                aluop_c   = ALUOP_SUB;
                pcsrc_c   = 2'b01;
                branch_c  = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc_c   = 2'b10;
                pcwrite_c = 1'b1;
                state_d   = S_FETCH;
            end
`ifdef MC_BNE_EN
            S_BNE: begin
                alusrca_c = 1'b1;
                aluop_c   = ALUOP_SUB;
                pcsrc_c   = 2'b01;
                bne_c     = 1'b1;
                state_d   = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    aludec u_aludec (
        .aluop_i      (aluop_c),
        .funct_i      (funct),
        .alucontrol_o (alucontrol_c)
    );

    // Reset masks every output combinationally so nothing waits for a clock edge.
    assign iord       = iord_c     & ~reset;
    assign memwrite   = memwrite_c & ~reset;
    assign irwrite    = irwrite_c  & ~reset;
    assign regdst     = regdst_c   & ~reset;
    assign memtoreg   = memtoreg_c & ~reset;
    assign regwrite   = regwrite_c & ~reset;
    assign alusrca    = alusrca_c  & ~reset;
    assign pcen       = ~reset & (pcwrite_c | (branch_c & zero) | (bne_c & ~zero));
    assign alusrcb    = reset ? 2'b00 : alusrcb_c;
    assign pcsrc      = reset ? 2'b00 : pcsrc_c;
    assign alucontrol = reset ? 3'b000 : alucontrol_c;
    assign state      = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expected state timelines plus
// a per-state output table, compared every cycle, with a few literal spot checks.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, memready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int compared = 0;
    int mismatched = 0;

    logic       chk_en  = 1'b0;
    logic       exp_rst = 1'b0;
    int         exp_state = 0;
    logic [5:0] cur_op = 6'd0, cur_funct = 6'd0;
    logic       cur_zero = 1'b0;
    int         mw_count;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memready   (memready),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .pcen       (pcen),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    always #5 clk = ~clk;

    wire [18:0] got_vec = {state, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                           alusrca, pcen, alusrcb, pcsrc, alucontrol};

    function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs from the state table; all outputs zero while reset is held.
    function automatic logic [18:0] model(input int st, input logic rst, input logic mr,
                                          input logic z, input logic [5:0] f);
        logic io, mwr, irw, rd, m2r, rw, sa, pe;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        io = 0; mwr = 0; irw = 0; rd = 0; m2r = 0; rw = 0; sa = 0; pe = 0;
        sb = 2'b00; ps = 2'b00; ac = 3'b010;
        if (rst) return 19'd0;
        case (st)
            0:  begin sb = 2'b01; irw = mr; pe = mr; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  io = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin io = 1; mwr = 1; end
            6:  begin sa = 1; ac = alu_of_funct(f); end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; ps = 2'b01; ac = 3'b110; pe = z; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pe = 1; end
            12: begin sa = 1; ps = 2'b01; ac = 3'b110; pe = ~z; end
            default: ;
        endcase
        return {4'(st), io, mwr, irw, rd, m2r, rw, sa, pe, sb, ps, ac};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic [18:0] e;
            e = model(exp_state, exp_rst, memready, zero, funct);
            compared++;
            if (got_vec !== e) begin
                mismatched++;
                $display("FAIL cycle t=%0t exp_state=%0d: got %05h expected %05h",
                         $time, exp_state, got_vec, e);
            end
        end
    end

    task automatic lchk(input string nm, input logic [31:0] g, input logic [31:0] e);
        compared++;
        if (g !== e) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, g, e);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    // One clock cycle in which the DUT is expected to sit in state st.
    task automatic cyc(input int st, input logic mr);
        @(posedge clk);
        #2;
        exp_state = st;
        memready  = mr;
        chk_en    = 1'b1;
        op        = (st == 1 || st == 2) ? cur_op : 6'($urandom);
        funct     = cur_funct;
        zero      = cur_zero;
    endtask

    task automatic set_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
        cur_op = o; cur_funct = f; cur_zero = z;
    endtask

    // Full instruction timeline with fw stall cycles in fetch and mw in the memory state.
    task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                         input int fw, input int mw);
        set_instr(o, f, z);
        repeat (fw) cyc(0, 1'b0);
        cyc(0, 1'b1);
        cyc(1, rb());
        case (o)
            6'b100011: begin cyc(2, rb()); repeat (mw) cyc(3, 1'b0); cyc(3, 1'b1); cyc(4, rb()); end
            6'b101011: begin cyc(2, rb()); repeat (mw) cyc(5, 1'b0); cyc(5, 1'b1); end
            6'b000000: begin cyc(6, rb()); cyc(7, rb()); end
            6'b000100: cyc(8, rb());
            6'b001000: begin cyc(9, rb()); cyc(10, rb()); end
            6'b000010: cyc(11, rb());
`ifdef MC_BNE_EN
            6'b000101: cyc(12, rb());
`endif
            default: ;
        endcase
    endtask

    initial begin
        reset = 1'b1; memready = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
        #3;
        lchk("reset_all_outputs_zero", 32'(got_vec), 32'd0);
        @(posedge clk);
        #2;
        memready = 1'b0;
        reset    = 1'b0;

        // lw, no stalls: 0,1,2,3,4 then back to 0
        set_instr(6'b100011, 6'd0, 1'b0);
        cyc(0, 1'b1); #4 lchk("lw_fetch_pcen", 32'(pcen), 32'd1);
        cyc(1, 1'b1); cyc(2, 1'b1); cyc(3, 1'b1);
        cyc(4, 1'b1); #4 lchk("lw_memwb_rw_m2r", 32'({regwrite, memtoreg}), 32'b11);

        // beq taken then not taken
        set_instr(6'b000100, 6'd0, 1'b1);
        cyc(0, 1'b1); cyc(1, 1'b1);
        cyc(8, 1'b1); #4 lchk("beq_z1_pcen", 32'(pcen), 32'd1);
        set_instr(6'b000100, 6'd0, 1'b0);
        cyc(0, 1'b1); #4 lchk("beq_back_to_fetch", 32'(state), 32'd0);
        cyc(1, 1'b1);
        cyc(8, 1'b1); #4 lchk("beq_z0_pcen", 32'(pcen), 32'd0);

        // R-type slt
        set_instr(6'b000000, 6'b101010, 1'b0);
        cyc(0, 1'b1); cyc(1, 1'b1);
        cyc(6, 1'b1); #4 lchk("slt_alucontrol", 32'(alucontrol), 32'b111);
        cyc(7, 1'b1); #4 lchk("slt_aluwb_rd_rw", 32'({regdst, regwrite}), 32'b11);

        // sw with three stall cycles in MEMWR
        set_instr(6'b101011, 6'd0, 1'b0);
        cyc(0, 1'b1); cyc(1, 1'b1); cyc(2, 1'b1);
        mw_count = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(5, (i == 3));
            #4 mw_count += int'(memwrite);
        end
        lchk("sw_memwrite_cycles", 32'(mw_count), 32'd4);

        // illegal op
        set_instr(6'b111111, 6'd0, 1'b0);
        cyc(0, 1'b1); #4 lchk("sw_done_state", 32'(state), 32'd0);
        cyc(1, 1'b1);
        cyc(0, 1'b0); #4 lchk("illegal_no_write", 32'({state, regwrite, memwrite}), 32'd0);

        // bne with zero=0
        set_instr(6'b000101, 6'd0, 1'b0);
        cyc(0, 1'b1); cyc(1, 1'b1);
`ifdef MC_BNE_EN
        cyc(12, 1'b1); #4 lchk("bne_pcen", 32'({state, pcen}), 32'({4'd12, 1'b1}));
`else
        cyc(0, 1'b0); #4 lchk("bne_disabled", 32'({state, pcen}), 32'd0);
`endif

        // Mixed instruction stream with stalls
        instr(6'b001000, 6'd0,      1'b0, 2, 0);
        instr(6'b000010, 6'd0,      1'b1, 0, 0);
        instr(6'b000000, 6'b100000, 1'b0, 1, 0);
        instr(6'b000000, 6'b100010, 1'b1, 0, 0);
        instr(6'b000000, 6'b100100, 1'b0, 0, 0);
        instr(6'b000000, 6'b100101, 1'b0, 3, 0);
        instr(6'b000000, 6'b111110, 1'b0, 0, 0);
        instr(6'b100011, 6'd0,      1'b0, 1, 2);
        instr(6'b101011, 6'd0,      1'b1, 0, 1);
        instr(6'b000100, 6'd0,      1'b1, 2, 0);
        instr(6'b000101, 6'd0,      1'b1, 0, 0);
        instr(6'b010101, 6'd0,      1'b0, 0, 0);

        // Reset asserted mid-store while memwrite is high
        set_instr(6'b101011, 6'd0, 1'b0);
        cyc(0, 1'b1); cyc(1, 1'b1); cyc(2, 1'b1);
        cyc(5, 1'b0);
        #4 lchk("memwr_before_reset", 32'(memwrite), 32'd1);
        reset = 1'b1; exp_rst = 1'b1;
        #1 lchk("reset_mid_memwr", 32'({state, memwrite, pcen, irwrite, regwrite}), 32'd0);
        @(posedge clk);
        #2 memready = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0; exp_rst = 1'b0; exp_state = 0; memready = 1'b0;

        instr(6'b100011, 6'd0, 1'b0, 0, 1);
        cyc(0, 1'b0);
        cyc(0, 1'b0);
        @(posedge clk);
        #2 chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge system clock.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: op  input  6  instr[31:26]; funct  input  6  instr[5:0]; zero  input  1  ALU zero flag.
REQ-004 SHALL have port: memready  input  1  unified memory completes the current access this cycle.
REQ-005 SHALL have outputs, each 1 bit: iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen.
REQ-006 SHALL have outputs: alusrcb  2; pcsrc  2; alucontrol  3; state  4 (debug, current state encoding).

Function
REQ-007 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, BNE=12; all unlisted outputs 0 in every state.
REQ-008 SHALL in FETCH drive alusrcb=01, aluop=00; irwrite=pcwrite=memready; stay in FETCH until memready=1, then go to DECODE.
REQ-009 SHALL in DECODE drive alusrcb=11, aluop=00; next state by op: 100011/101011->MEMADR, 000000->EXEC, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, 000101->BNE (macro only), any other op->FETCH (illegal op is a no-op).
REQ-010 SHALL in MEMADR drive alusrca=1, alusrcb=10; go to MEMRD if op=100011, else MEMWR.
REQ-011 SHALL in MEMRD drive iord=1; hold until memready=1, then MEMWB; MEMWB drives memtoreg=1, regwrite=1, regdst=0, then FETCH.
REQ-012 SHALL in MEMWR drive iord=1, memwrite=1 every cycle until memready=1, then FETCH.
REQ-013 SHALL in EXEC drive alusrca=1, alusrcb=00, aluop=10, then ALUWB: regdst=1, regwrite=1, then FETCH.
REQ-014 SHALL in ADDIEX drive alusrca=1, alusrcb=10, aluop=00, then ADDIWB: regwrite=1, regdst=0, memtoreg=0, then FETCH.
REQ-015 SHALL in BRANCH drive alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, then FETCH.
REQ-016 SHALL in JUMP drive pcsrc=10, pcwrite=1, then FETCH.
REQ-017 SHALL compute pcen = pcwrite | (branch & zero) | (bne & ~zero), combinationally in the same cycle.
REQ-018 SHALL decode alucontrol: aluop 00->010, 01->110, 10 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other funct->010.
REQ-019 SHALL give latency with memready held 1: j/beq/bne 3 cycles, R-type/addi/sw 4, lw 5; each memready=0 cycle in FETCH/MEMRD/MEMWR adds one.
REQ-020 SHALL sample op/funct only in DECODE/MEMADR; changes elsewhere have no effect on state sequence.

Reset
REQ-021 SHALL on reset=1 immediately (no clock needed) set state=FETCH and force pcen, irwrite, memwrite, regwrite to 0; all other outputs 0.
REQ-022 SHALL abandon any in-progress instruction on reset mid-operation, including MEMWR with memwrite high; first fetch follows the first rising clk after release.

Configuration
REQ-023 SHALL, with MC_BNE_EN defined, implement BNE: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, bne=1, then FETCH.
REQ-024 SHALL, without MC_BNE_EN, omit state BNE; op 000101 treated as illegal (DECODE->FETCH), bne term of pcen constant 0.

Structure
REQ-025 SHALL take state enum, opcode constants, funct constants and aluop codes from shared package mc_pkg.
REQ-026 SHALL contain one sub-module aludec (aluop, funct -> alucontrol), purely combinational; FSM lives in the top.

Verification
REQ-027 Reset: assert reset mid-MEMWR -> state=0, memwrite=0 within same cycle, no clock edge needed.
REQ-028 lw (op=100011), memready=1 -> states 0,1,2,3,4,0; regwrite=1 only in state 4 with memtoreg=1.
REQ-029 sw with memready low 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then state=0.
REQ-030 beq, zero=1 -> pcen=1 in BRANCH; zero=0 -> pcen=0; both return to FETCH after 3 cycles.
REQ-031 R-type funct=101010 -> alucontrol=111 in EXEC, regdst=1 & regwrite=1 in ALUWB; op=111111 -> DECODE->FETCH, no write enable.
REQ-032 op=000101, zero=0 -> with MC_BNE_EN pcen=1 in state 12; without, state returns 0 after DECODE, pcen stays 0.
